// File: rtl/serializer_pkg.sv
// Shared types and helpers for the parametrised parallel-to-serial shifter.
package serializer_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_e;

  // A requested length of 0, or anything longer than the word, means a full word.
  function automatic int unsigned norm_len(input int unsigned len, input int unsigned data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/serializer_mc_if.sv
// Frame request / serial output bundle between the word producer and serializer_mc.
interface serializer_mc_if #(
  parameter int DATA_W = 27,
  parameter int LEN_W  = $clog2(DATA_W + 1)
);
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic [LEN_W-1:0]  len_i;
  logic              lsb_first_i;
  logic              ready_o;
  logic              data_o;
  logic              ena_o;
  logic              bit_stb_o;
  logic              done_o;

  modport master (
    output start_i, data_i, len_i, lsb_first_i,
    input  ready_o, data_o, ena_o, bit_stb_o, done_o
  );

  modport slave (
    input  start_i, data_i, len_i, lsb_first_i,
    output ready_o, data_o, ena_o, bit_stb_o, done_o
  );
endinterface

// File: rtl/serializer_mc_bit_period_ctr.sv
// Bit-period divider: counts 0..BIT_DIV-1 while run_i is high, parked at 0 otherwise.
module bit_period_ctr #(
  parameter int BIT_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  output logic tick_o,
  output logic first_o
);
  localparam int CNT_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (!run_i || cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick_o  = run_i && (cnt_q == LAST);
  assign first_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/serializer_mc.sv
// Parametrised parallel-to-serial shifter with start/ready handshake and done pulse.
module serializer_mc
  import serializer_pkg::*;
#(
  parameter int   DATA_W   = 27,
  parameter int   BIT_DIV  = 4,
  parameter logic IDLE_LVL = 1'b0,
  parameter int   LEN_W    = $clog2(DATA_W + 1)
) (
  input logic             clk_i,
  input logic             rst_ni,
  serializer_mc_if.slave  bus
);

  logic [1:0]        state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  bit_cnt_q;
  logic              lsb_q;
  logic              data_q;

  logic              ready;
  logic              accept;
  logic              tick;
  logic              first;
  logic [LEN_W-1:0]  eff_len;
  logic [DATA_W-1:0] load_word;
  logic              load_bit;
  logic [DATA_W-1:0] shifted;
  logic              shifted_bit;

  assign ready  = (state_q != ST_SHIFT);
  assign accept = bus.start_i && ready;

  assign eff_len = LEN_W'(norm_len(32'(bus.len_i), DATA_W));

  // MSB-first words are left-aligned so the current bit always sits at the top.
  assign load_word = bus.lsb_first_i ? bus.data_i
                                     : (bus.data_i << (LEN_W'(DATA_W) - eff_len));
  assign load_bit  = bus.lsb_first_i ? load_word[0] : load_word[DATA_W-1];

  assign shifted     = lsb_q ? (shreg_q >> 1) : (shreg_q << 1);
  assign shifted_bit = lsb_q ? shifted[0] : shifted[DATA_W-1];

  bit_period_ctr #(
    .BIT_DIV (BIT_DIV)
  ) u_period (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .run_i   (state_q == ST_SHIFT),
    .tick_o  (tick),
    .first_o (first)
  );

  // NOTE: the shift register is reset along with control so data_o never exposes X after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      shreg_q   <= '0;
      len_q     <= '0;
      bit_cnt_q <= '0;
      lsb_q     <= 1'b0;
      data_q    <= IDLE_LVL;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            shreg_q   <= load_word;
            len_q     <= eff_len;
            lsb_q     <= bus.lsb_first_i;
            bit_cnt_q <= '0;
            data_q    <= load_bit;
            state_q   <= ST_SHIFT;
          end else begin
            state_q   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (bit_cnt_q == len_q - LEN_W'(1)) begin
              state_q   <= ST_DONE;
              data_q    <= IDLE_LVL;
              bit_cnt_q <= '0;
            end else begin
              shreg_q   <= shifted;
              data_q    <= shifted_bit;
              bit_cnt_q <= bit_cnt_q + LEN_W'(1);
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          data_q  <= IDLE_LVL;
        end
      endcase
    end
  end

  assign bus.ready_o   = ready;
  assign bus.data_o    = data_q;
  assign bus.ena_o     = (state_q == ST_SHIFT);
  assign bus.bit_stb_o = first;
  assign bus.done_o    = (state_q == ST_DONE);

endmodule

// File: doc/serializer_mc.md
Name: serializer_mc

Overview:
Parametrised parallel-to-serial shifter. It is the next generation of the fixed 27-bit serializer, now with configurable word width and bit period, runtime frame length and bit order, a ready/start handshake, and a completion pulse. It sits between a word-producing control block and a single-wire serial output, such as a DAC or shift-register chain, with an ena_o qualifier for the downstream receiver.

Parameters:
DATA_W, 27, maximum word width in bits (>=2)
BIT_DIV, 4, clock cycles per serial bit (>=1)
IDLE_LVL, 1'b0, level driven on data_o when no frame is active
LEN_W, $clog2(DATA_W+1), width of len_i

Ports:
clk_i  in  1  system clock, rising edge
rst_ni  in  1  asynchronous active-low reset
start_i  in  1  frame request; accepted when start_i && ready_o at a rising edge
data_i  in  DATA_W  word to send, captured on accept
len_i  in  LEN_W  bits to send, captured on accept; 0 means DATA_W; values >DATA_W clamp to DATA_W
lsb_first_i  in  1  bit order, captured on accept: 1 = bit 0 first, 0 = bit len-1 first
ready_o  out  1  block can accept a frame
data_o  out  1  serial data, registered
ena_o  out  1  high for every cycle data_o carries a frame bit
bit_stb_o  out  1  one-cycle pulse on the first cycle of each bit period
done_o  out  1  one-cycle pulse after the last bit period

Behaviour:
- Clock and reset: one clock, clk_i. rst_ni is asynchronous and active-low.
- Reset values: state=IDLE, ready_o=1, data_o=IDLE_LVL, ena_o=0, bit_stb_o=0, done_o=0, all counters 0.
- FSM states:
  - IDLE: ready_o=1.
    - On accept: load the shift register with data_i and latch the effective length N and the bit order.
    - At the same edge, drive the first bit to data_o and set ena_o=1 and bit_stb_o=1. Go to SHIFT.
  - SHIFT: ready_o=0.
    - div_cnt counts 0..BIT_DIV-1; each bit is held for exactly BIT_DIV cycles.
    - On div_cnt wrap, if bit_cnt<N-1: shift, drive the next bit, pulse bit_stb_o, increment bit_cnt.
    - On div_cnt wrap with bit_cnt==N-1: go to DONE with data_o=IDLE_LVL and ena_o=0.
  - DONE: one cycle. done_o=1 and ready_o=1.
    - Accept in DONE starts a new frame exactly as from IDLE.
    - Otherwise go to IDLE.
- Latency and throughput:
  - First bit is visible in the cycle after the accepting edge.
  - ena_o stays high for exactly N*BIT_DIV consecutive cycles.
  - done_o rises one cycle after ena_o falls.
  - Minimum gap between back-to-back frames is 1 cycle (the DONE cycle).
- MSB-first mode: the bit sent at position k is data[N-1-k]. LSB-first mode: it is data[k]. Bits at or above N are never sent.
- BIT_DIV=1: bit_stb_o is high every cycle of the frame.
- start_i while ready_o=0 is ignored. There is no queueing, and data_i/len_i changes have no effect mid-frame.
- Reset asserted mid-frame: outputs return to reset values immediately (asynchronously) and the frame is abandoned. done_o is not produced. After release, the block is in IDLE with ready_o=1.
- Counter widths: bit_cnt is LEN_W; div_cnt is max(1,$clog2(BIT_DIV)). No counter ever wraps beyond its terminal value.

Decomposition:
- serializer_pkg: state enum (IDLE, SHIFT, DONE) and a len-normalise function (0 or >DATA_W maps to DATA_W).
- Sub-module bit_period_ctr: parametrised on BIT_DIV, with inputs clk_i, rst_ni and a run/restart control. It outputs a tick on the last cycle of each period and a first-cycle strobe. serializer_mc instantiates one.

Test Plan:
All scenarios use DATA_W=27, BIT_DIV=4, IDLE_LVL=0.
- Reset: hold rst_ni=0 with random inputs -> ready_o=1, data_o=0, ena_o=0, bit_stb_o=0, done_o=0. Assert rst_ni asynchronously between edges -> outputs clear without waiting for a clock edge.
- MSB-first full word: data_i=27'h4000001, len_i=0, lsb_first_i=0 -> data_o=1 for 4 cycles, 0 for 100 cycles, 1 for 4 cycles. Also: ena_o high 108 cycles, 27 bit_stb_o pulses, done_o at cycle 109 after accept.
- LSB-first short frame: data_i=27'h00000B2, len_i=8, lsb_first_i=1 -> bit sequence 0,1,0,0,1,1,0,1, each held 4 cycles. Also: ena_o high 32 cycles, one done_o pulse.
- Back-to-back and ignored start: start_i held high for two frames with len_i=3 -> second frame's first bit appears 1 cycle after done_o. A start pulse mid-frame with different data_i -> no effect.
- Reset mid-frame: drop rst_ni during bit 5 of a 27-bit frame -> data_o=0, ena_o=0 immediately and no done_o. After release a new start sends a complete correct frame.
- Length edge cases: len_i=31 -> clamped, 27 bits sent. len_i=1 -> a single bit for 4 cycles, then done_o.
